// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, opcode values and instruction decode shared by the TAP front end.
package jtag_pkg;
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;
  localparam int EXTEST = 0;
  localparam int IDCODE = 1;
  localparam int SAMPLE = 2;
  localparam int USER_BASE = 4;
  localparam int SEL_BYPASS = -1;
  localparam int SEL_IDCODE = -2;
  // External DR index for an instruction, or SEL_BYPASS / SEL_IDCODE for the internal registers
  function automatic int decode_sel(input int ir, input int ir_w, input int num_dr, input bit has_idcode);
    int ones;
    ones = (1 << ir_w) - 1;
    if (ir == ones) return SEL_BYPASS;
    if (ir == EXTEST || ir == SAMPLE) return 0;
    if (ir == IDCODE) return has_idcode ? SEL_IDCODE : SEL_BYPASS;
    if (ir >= USER_BASE && ir < USER_BASE + num_dr) return ir - USER_BASE;
    return SEL_BYPASS;
  endfunction
endpackage

// File: rtl/jtag_tap_param_top_fsm.sv
// jtag_tap_fsm: 16-state TAP controller; exports the next state plus registered-state decodes.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCLK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_t state_nxt,
  output logic       tlr,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir
);
  tap_state_t state_q, state_d;
  always_ff @(posedge TCLK or negedge TRST)
    if (!TRST) state_q <= TLR;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:    state_d = TMS ? TLR    : RTI;
      RTI:    state_d = TMS ? SEL_DR : RTI;
      SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_d = TMS ? UPD_DR : PAU_DR;
      PAU_DR: state_d = TMS ? EX2_DR : PAU_DR;
      EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_d = TMS ? SEL_DR : RTI;
      SEL_IR: state_d = TMS ? TLR    : CAP_IR;
      CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_d = TMS ? UPD_IR : PAU_IR;
      PAU_IR: state_d = TMS ? EX2_IR : PAU_IR;
      EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_d = TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
    state_nxt  = state_d;
    tlr        = state_q == TLR;
    capture_dr = state_q == CAP_DR;
    shift_dr   = state_q == SH_DR;
    update_dr  = state_q == UPD_DR;
    capture_ir = state_q == CAP_IR;
    shift_ir   = state_q == SH_IR;
    update_ir  = state_q == UPD_IR;
  end
endmodule

// File: rtl/jtag_tap_param_top.sv
// jtag_tap_param_top: parametrised JTAG front end with IR, decode, BYPASS/IDCODE and external DR strobes.
module jtag_tap_param_top
  import jtag_pkg::*;
#(
  parameter int          IR_W       = 4,
  parameter int          NUM_DR     = 2,
  parameter logic [31:0] IDCODE_VAL = 32'h1923_4001,
  parameter bit          HAS_IDCODE = 1
) (
  input  logic              TCLK,
  input  logic              TRST,
  input  logic              TMS,
  input  logic              TDI,
  output logic              TDO,
  output logic              tdo_en,
  input  logic [NUM_DR-1:0] dr_tdo,
  output logic [NUM_DR-1:0] dr_sel,
  output logic              capture_dr,
  output logic              shift_dr,
  output logic              update_dr,
  output logic [IR_W-1:0]   ir_q,
  output logic              tlr
);
  localparam logic [IR_W-1:0] RST_IR = HAS_IDCODE ? IR_W'(IDCODE) : {IR_W{1'b1}};
  tap_state_t state_nxt;
  logic st_cap_dr, st_sh_dr, st_upd_dr, st_cap_ir, st_sh_ir, st_upd_ir;
  logic [IR_W-1:0] ir_d, ir_sh_q, ir_sh_d;
  logic byp_q, byp_d;
  logic [31:0] id_q, id_d;
  int sel;
  jtag_tap_fsm u_fsm (
    .TCLK       (TCLK),
    .TRST       (TRST),
    .TMS        (TMS),
    .state_nxt  (state_nxt),
    .tlr        (tlr),
    .capture_dr (st_cap_dr),
    .shift_dr   (st_sh_dr),
    .update_dr  (st_upd_dr),
    .capture_ir (st_cap_ir),
    .shift_ir   (st_sh_ir),
    .update_ir  (st_upd_ir)
  );
  always_ff @(posedge TCLK or negedge TRST)
    if (!TRST) begin
      ir_q    <= RST_IR;
      ir_sh_q <= '0;
      byp_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      ir_q    <= ir_d;
      ir_sh_q <= ir_sh_d;
      byp_q   <= byp_d;
      id_q    <= id_d;
    end
  // Entering TLR through TMS reloads the instruction but leaves the shift registers alone
  always_comb begin
    sel = decode_sel(int'(ir_q), IR_W, NUM_DR, HAS_IDCODE);
    dr_sel = '0;
    for (int k = 0; k < NUM_DR; k++) dr_sel[k] = sel == k;
    ir_d    = state_nxt == TLR ? RST_IR : st_upd_ir ? ir_sh_q : ir_q;
    ir_sh_d = st_cap_ir ? IR_W'(1) : st_sh_ir ? {TDI, ir_sh_q[IR_W-1:1]} : ir_sh_q;
    byp_d   = st_cap_dr ? 1'b0 : st_sh_dr ? TDI : byp_q;
    id_d    = st_cap_dr ? IDCODE_VAL : st_sh_dr ? {TDI, id_q[31:1]} : id_q;
    capture_dr = st_cap_dr & |dr_sel;
    shift_dr   = st_sh_dr & |dr_sel;
    update_dr  = st_upd_dr & |dr_sel;
    tdo_en     = st_sh_dr | st_sh_ir;
    TDO = st_sh_ir ? ir_sh_q[0] : !st_sh_dr ? 1'b0 : |dr_sel ? |(dr_tdo & dr_sel) :
          sel == SEL_IDCODE ? id_q[0] : byp_q;
  end
endmodule

// File: tb/tb_jtag_tap_param_top.sv
// tb_jtag_tap_param_top: two TAP configurations driven in lockstep and checked every cycle
// against a table-driven behavioural model, plus directed literal expectations.
module tb_jtag_tap_param_top;
  logic TCLK = 0, TRST = 1, TMS = 1, TDI = 0;
  logic [1:0] dr_tdo = 2'b00;
  logic tdo0, en0, cd0, sd0, ud0, tlr0, tdo1, en1, cd1, sd1, ud1, tlr1;
  logic [1:0] sel0;
  logic [0:0] sel1;
  logic [3:0] ir0, ir1, o4;
  logic [31:0] o32;
  int errs = 0, checks = 0;
  bit chk_on = 0;
  always #5 TCLK = ~TCLK;
  jtag_tap_param_top u_dut0 (
    .TCLK(TCLK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(tdo0), .tdo_en(en0),
    .dr_tdo(dr_tdo), .dr_sel(sel0), .capture_dr(cd0), .shift_dr(sd0), .update_dr(ud0),
    .ir_q(ir0), .tlr(tlr0)
  );
  jtag_tap_param_top #(.NUM_DR(1), .HAS_IDCODE(0)) u_dut1 (
    .TCLK(TCLK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(tdo1), .tdo_en(en1),
    .dr_tdo(dr_tdo[0:0]), .dr_sel(sel1), .capture_dr(cd1), .shift_dr(sd1), .update_dr(ud1),
    .ir_q(ir1), .tlr(tlr1)
  );
  localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7, UDR = 8;
  localparam int SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;
  int n0[16] = '{RTI, RTI, CDR, SHDR, SHDR, PDR, PDR, SHDR, RTI, CIR, SHIR, SHIR, PIR, PIR, SHIR, RTI};
  int n1[16] = '{TLR, SDR, SIR, E1DR, E1DR, UDR, E2DR, UDR, SDR, TLR, E1IR, E1IR, UIR, E2IR, UIR, SDR};
  int nd[2] = '{2, 1};
  bit hid[2] = '{1'b1, 1'b0};
  int st[2], ir[2], irsh[2];
  bit byp[2];
  logic [31:0] idr[2];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic int rst_ir(input int i);
    return hid[i] ? 1 : 15;
  endfunction
  // -2 IDCODE, -1 BYPASS, otherwise external DR index
  function automatic int msel(input int i);
    int v;
    v = ir[i];
    if (v == 0 || v == 2) return 0;
    if (v == 1) return hid[i] ? -2 : -1;
    if (v >= 4 && v < 4 + nd[i] && v != 15) return v - 4;
    return -1;
  endfunction
  always @(posedge TCLK or negedge TRST)
    for (int i = 0; i < 2; i++) begin
      if (!TRST) begin
        st[i] = TLR; ir[i] = rst_ir(i); irsh[i] = 0; byp[i] = 0; idr[i] = 0;
      end else begin
        int nx;
        nx = TMS ? n1[st[i]] : n0[st[i]];
        if (st[i] == CIR) irsh[i] = 1;
        if (st[i] == SHIR) irsh[i] = (irsh[i] >> 1) | (TDI ? 8 : 0);
        if (st[i] == UIR) ir[i] = irsh[i];
        if (st[i] == CDR) begin byp[i] = 0; idr[i] = 32'h1923_4001; end
        if (st[i] == SHDR) begin byp[i] = TDI; idr[i] = {TDI, idr[i][31:1]}; end
        if (nx == TLR) ir[i] = rst_ir(i);
        st[i] = nx;
      end
    end
  always @(negedge TCLK)
    if (chk_on)
      for (int i = 0; i < 2; i++) begin
        int s;
        logic [1:0] es;
        logic et;
        s = msel(i);
        es = s < 0 ? 2'b00 : 2'(1 << s);
        et = st[i] == SHIR ? irsh[i][0] : st[i] != SHDR ? 1'b0 : s >= 0 ? dr_tdo[s] :
             s == -2 ? idr[i][0] : byp[i];
        chk($sformatf("tdo%0d", i), i ? 32'(tdo1) : 32'(tdo0), 32'(et));
        chk($sformatf("tdo_en%0d", i), i ? 32'(en1) : 32'(en0), 32'(st[i] == SHDR || st[i] == SHIR));
        chk($sformatf("dr_sel%0d", i), i ? 32'(sel1) : 32'(sel0), 32'(es));
        chk($sformatf("capture_dr%0d", i), i ? 32'(cd1) : 32'(cd0), 32'(st[i] == CDR && es != 0));
        chk($sformatf("shift_dr%0d", i), i ? 32'(sd1) : 32'(sd0), 32'(st[i] == SHDR && es != 0));
        chk($sformatf("update_dr%0d", i), i ? 32'(ud1) : 32'(ud0), 32'(st[i] == UDR && es != 0));
        chk($sformatf("ir_q%0d", i), i ? 32'(ir1) : 32'(ir0), 32'(ir[i]));
        chk($sformatf("tlr%0d", i), i ? 32'(tlr1) : 32'(tlr0), 32'(st[i] == TLR));
      end
  task automatic step(input logic tms, input logic tdi);
    #2;
    TMS = tms; TDI = tdi; dr_tdo = 2'($urandom);
    @(posedge TCLK);
    @(negedge TCLK);
  endtask
  task automatic tms_seq(input logic [15:0] bits, input int n);
    for (int k = 0; k < n; k++) step(bits[k], 1'($urandom));
  endtask
  task automatic load_ir(input logic [3:0] v, output logic [3:0] out);
    tms_seq(16'b0011, 4);
    for (int k = 0; k < 4; k++) begin out[k] = tdo0; step(k == 3, v[k]); end
    tms_seq(16'b01, 2);
  endtask
  task automatic shift_dr(input logic [31:0] din, input int n, output logic [31:0] out);
    out = '0;
    tms_seq(16'b001, 3);
    for (int k = 0; k < n; k++) begin out[k] = tdo0; step(k == n - 1, din[k]); end
    tms_seq(16'b01, 2);
  endtask
  initial begin
    #1 TRST = 0;
    chk_on = 1;
    @(negedge TCLK);
    chk("rst_tlr", 32'(tlr0), 1);
    chk("rst_ir0", 32'(ir0), 4'h1);
    chk("rst_ir1", 32'(ir1), 4'hF);
    chk("rst_tdo_en", 32'(en0), 0);
    #2 TRST = 1;
    @(negedge TCLK);
    step(0, 0);
    shift_dr(32'($urandom), 32, o32);
    chk("idcode_shift", o32, 32'h1923_4001);
    load_ir(4'hF, o4);
    chk("ir_capture", 32'(o4), 4'h1);
    shift_dr(32'hD, 4, o32);
    chk("bypass_shift", o32, 4'hA);
    chk("bypass_sel", 32'(sel0), 0);
    load_ir(4'h5, o4);
    chk("user1_sel", 32'(sel0), 2'b10);
    tms_seq(16'b01, 2);
    chk("user1_capture", 32'(cd0), 1);
    chk("nd1_user1_capture", 32'(cd1), 0);
    step(0, 1);
    chk("user1_shift", 32'(sd0), 1);
    tms_seq(16'b11, 2);
    chk("user1_update", 32'(ud0), 1);
    step(0, 0);
    load_ir(4'h9, o4);
    chk("undef_sel", 32'(sel0), 0);
    shift_dr(32'hD, 4, o32);
    chk("undef_bypass", o32, 4'hA);
    tms_seq(16'b010011, 6);
    tms_seq(16'b1111, 4);
    chk("pause_ir_tlr4", 32'(tlr0), 0);
    step(1, 0);
    chk("pause_ir_tlr5", 32'(tlr0), 1);
    chk("pause_ir_ir", 32'(ir0), 4'h1);
    step(0, 0);
    load_ir(4'h5, o4);
    tms_seq(16'b001, 3);
    tms_seq(16'b1111, 4);
    chk("shdr_tlr4", 32'(tlr0), 0);
    chk("shdr_ir4", 32'(ir0), 4'h5);
    step(1, 0);
    chk("shdr_tlr5", 32'(tlr0), 1);
    chk("shdr_ir5", 32'(ir0), 4'h1);
    step(0, 0);
    load_ir(4'h5, o4);
    tms_seq(16'b0011, 4);
    step(0, 0);
    step(0, 0);
    #3 TRST = 0;
    #1;
    chk("trst_ir0", 32'(ir0), 4'h1);
    chk("trst_ir1", 32'(ir1), 4'hF);
    chk("trst_tlr", 32'(tlr0), 1);
    chk("trst_no_update", 32'(ud0), 0);
    @(negedge TCLK);
    #2 TMS = 1; TRST = 1;
    @(negedge TCLK);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        #3 TRST = 0;
        @(negedge TCLK);
        #1 TRST = 1;
      end
      step($urandom_range(0, 99) < 30, 1'($urandom));
    end
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
